// File: rtl/rs_pkg.sv
// Shared constants and enums for the receive Reconciliation Sublayer.
package rs_pkg;

    localparam logic [7:0] START      = 8'hDF;
    localparam logic [7:0] PREAMBLE   = 8'h55;
    localparam logic [7:0] SEQUENCE   = 8'h59;
    localparam logic [7:0] IDLE       = 8'hE0;
    localparam logic [7:0] SEQ_LOCAL  = 8'h80;
    localparam logic [7:0] SEQ_REMOTE = 8'hC0;

    typedef enum logic [1:0] {
        INIT,
        COUNT,
        FAULT
    } lf_state_t;

    typedef enum logic {
        FT_LOCAL,
        FT_REMOTE
    } fault_type_t;

endpackage

// File: rtl/rs_link_fault.sv
// Link-fault state machine: counts same-type Sequence columns to declare a fault,
// and clears after CLEAR_COLS columns with no Sequence.
module rs_link_fault
    import rs_pkg::*;
#(
    parameter int unsigned FAULT_CNT  = 4,
    parameter int unsigned CLEAR_COLS = 128
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic        col_valid,
    input  logic        seq_col,
    input  fault_type_t seq_type,
    output logic        local_fault,
    output logic        remote_fault
);

    localparam int unsigned SEQ_W = $clog2(FAULT_CNT + 1);
    localparam int unsigned CNT_W = $clog2(CLEAR_COLS + 1);

    lf_state_t          state;
    fault_type_t        cur_type;
    logic [SEQ_W-1:0]   seq_cnt;
    logic [CNT_W-1:0]   col_cnt;
    logic [SEQ_W-1:0]   seq_inc;
    logic [CNT_W-1:0]   col_inc;

    always_comb begin
        seq_inc = seq_cnt + 1'b1;
        col_inc = (col_cnt == CNT_W'(CLEAR_COLS)) ? col_cnt : col_cnt + 1'b1;
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state        <= INIT;
            cur_type     <= FT_LOCAL;
            seq_cnt      <= '0;
            col_cnt      <= '0;
            local_fault  <= 1'b0;
            remote_fault <= 1'b0;
        end else if (col_valid) begin
            unique case (state)
                INIT: begin
                    if (seq_col) begin
                        cur_type <= seq_type;
                        seq_cnt  <= SEQ_W'(1);
                        col_cnt  <= '0;
                        if (FAULT_CNT <= 1) begin
                            state        <= FAULT;
                            local_fault  <= (seq_type == FT_LOCAL);
                            remote_fault <= (seq_type == FT_REMOTE);
                        end else begin
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (seq_col) begin
                        col_cnt <= '0;
                        if (seq_type == cur_type) begin
                            seq_cnt <= seq_inc;
                            if (seq_inc == SEQ_W'(FAULT_CNT)) begin
                                state        <= FAULT;
                                local_fault  <= (seq_type == FT_LOCAL);
                                remote_fault <= (seq_type == FT_REMOTE);
                            end
                        end else begin
                            cur_type <= seq_type;
                            seq_cnt  <= SEQ_W'(1);
                        end
                    end else if (col_inc == CNT_W'(CLEAR_COLS)) begin
                        state   <= INIT;
                        seq_cnt <= '0;
                        col_cnt <= '0;
                    end else begin
                        col_cnt <= col_inc;
                    end
                end
                FAULT: begin
                    if (seq_col) begin
                        col_cnt <= '0;
                        if (seq_type != cur_type) begin
                            state        <= COUNT;
                            cur_type     <= seq_type;
                            seq_cnt      <= SEQ_W'(1);
                            local_fault  <= 1'b0;
                            remote_fault <= 1'b0;
                        end
                    end else if (col_inc == CNT_W'(CLEAR_COLS)) begin
                        state        <= INIT;
                        seq_cnt      <= '0;
                        col_cnt      <= '0;
                        local_fault  <= 1'b0;
                        remote_fault <= 1'b0;
                    end else begin
                        col_cnt <= col_inc;
                    end
                end
                default: begin
                    state        <= INIT;
                    local_fault  <= 1'b0;
                    remote_fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rx_rs_align.sv
// Receive RS front end: packs RATIO input columns per output word, realigning on
// Start so it lands in lane 0, and feeds Sequence columns to the link-fault FSM.
module rx_rs_align
    import rs_pkg::*;
#(
    parameter int unsigned IN_LANES   = 4,
    parameter int unsigned RATIO      = 2,
    parameter int unsigned FAULT_CNT  = 4,
    parameter int unsigned CLEAR_COLS = 128
) (
    input  logic                         rxclk,
    input  logic                         reset,
    input  logic [8*IN_LANES-1:0]        rxd_in,
    input  logic [IN_LANES-1:0]          rxc_in,
    input  logic                         in_valid,
    output logic [8*IN_LANES*RATIO-1:0]  rxd64,
    output logic [IN_LANES*RATIO-1:0]    rxc8,
    output logic                         out_valid,
    output logic                         local_fault,
    output logic                         remote_fault,
    output logic                         align_err
);

    localparam int unsigned COL_W = 8 * IN_LANES;
    localparam int unsigned PH_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [PH_W-1:0]             phase;
    logic [COL_W*RATIO-1:0]      pack_d, full_d, flush_d;
    logic [IN_LANES*RATIO-1:0]   pack_c, full_c, flush_c;
    logic                        is_start, is_misplaced, is_seq;
    fault_type_t                 seq_type;

    always_comb begin
        is_start = (rxd_in[7:0] == START) && rxc_in[0] &&
                   (rxd_in[15:8] == PREAMBLE) && !rxc_in[1];
        is_misplaced = 1'b0;
        for (int unsigned k = 1; k < IN_LANES; k++) begin
            if ((rxd_in[8*k +: 8] == START) && rxc_in[k]) is_misplaced = 1'b1;
        end
        is_seq = (rxd_in[7:0] == SEQUENCE) && rxc_in[0] && (rxc_in[3:1] == 3'b000) &&
                 (rxd_in[23:8] == 16'h0000) &&
                 ((rxd_in[31:24] == SEQ_LOCAL) || (rxd_in[31:24] == SEQ_REMOTE));
        seq_type = (rxd_in[31:24] == SEQ_REMOTE) ? FT_REMOTE : FT_LOCAL;
    end

    // full_*: word completed by the current column; flush_*: partial word padded with IDLE
    always_comb begin
        full_d  = pack_d;
        full_c  = pack_c;
        flush_d = pack_d;
        flush_c = pack_c;
        for (int unsigned s = 0; s < RATIO; s++) begin
            if (s == 32'(phase)) begin
                full_d[s*COL_W +: COL_W]       = rxd_in;
                full_c[s*IN_LANES +: IN_LANES] = rxc_in;
            end
            if (s >= 32'(phase)) begin
                flush_d[s*COL_W +: COL_W]       = {IN_LANES{IDLE}};
                flush_c[s*IN_LANES +: IN_LANES] = '1;
            end
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            phase     <= '0;
            pack_d    <= '0;
            pack_c    <= '0;
            rxd64     <= '0;
            rxc8      <= '0;
            out_valid <= 1'b0;
            align_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            align_err <= in_valid && is_misplaced;
            if (in_valid) begin
                if (is_start && (phase != '0)) begin
                    rxd64                 <= flush_d;
                    rxc8                  <= flush_c;
                    out_valid             <= 1'b1;
                    pack_d[COL_W-1:0]     <= rxd_in;
                    pack_c[IN_LANES-1:0]  <= rxc_in;
                    phase                 <= PH_W'(1);
                end else if (32'(phase) == RATIO - 1) begin
                    rxd64     <= full_d;
                    rxc8      <= full_c;
                    out_valid <= 1'b1;
                    phase     <= '0;
                end else begin
                    pack_d[32'(phase)*COL_W +: COL_W]       <= rxd_in;
                    pack_c[32'(phase)*IN_LANES +: IN_LANES] <= rxc_in;
                    phase <= phase + 1'b1;
                end
            end
        end
    end

    rs_link_fault #(
        .FAULT_CNT  (FAULT_CNT),
        .CLEAR_COLS (CLEAR_COLS)
    ) u_link_fault (
        .rxclk        (rxclk),
        .reset        (reset),
        .col_valid    (in_valid),
        .seq_col      (is_seq),
        .seq_type     (seq_type),
        .local_fault  (local_fault),
        .remote_fault (remote_fault)
    );

endmodule

// File: tb/tb_rx_rs_align.sv
// Randomised and directed bench for rx_rs_align against a column-level reference model.
module tb_rx_rs_align;

    localparam int unsigned LANES = 4;
    localparam int unsigned RAT   = 2;
    localparam int unsigned FCNT  = 4;
    localparam int unsigned CCOLS = 128;

    logic                    rxclk = 1'b0;
    logic                    reset = 1'b1;
    logic [8*LANES-1:0]      rxd_in = '0;
    logic [LANES-1:0]        rxc_in = '0;
    logic                    in_valid = 1'b0;
    logic [8*LANES*RAT-1:0]  rxd64;
    logic [LANES*RAT-1:0]    rxc8;
    logic                    out_valid, local_fault, remote_fault, align_err;

    rx_rs_align #(
        .IN_LANES   (LANES),
        .RATIO      (RAT),
        .FAULT_CNT  (FCNT),
        .CLEAR_COLS (CCOLS)
    ) dut (
        .rxclk        (rxclk),
        .reset        (reset),
        .rxd_in       (rxd_in),
        .rxc_in       (rxc_in),
        .in_valid     (in_valid),
        .rxd64        (rxd64),
        .rxc8         (rxc8),
        .out_valid    (out_valid),
        .local_fault  (local_fault),
        .remote_fault (remote_fault),
        .align_err    (align_err)
    );

    always #5 rxclk = ~rxclk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: columns waiting for a word, plus a Sequence run tracker
    logic [31:0] mq_d[$];
    logic [3:0]  mq_c[$];
    logic        exp_ov, exp_ae, exp_lf, exp_rf;
    logic [63:0] exp_d;
    logic [7:0]  exp_c;
    bit          tracking, faulted;
    int          run_len, quiet;
    logic [7:0]  run_type;

    function automatic void model_reset();
        mq_d.delete();
        mq_c.delete();
        exp_ov = 0; exp_ae = 0; exp_lf = 0; exp_rf = 0;
        exp_d = '0; exp_c = '0;
        tracking = 0; faulted = 0; run_len = 0; quiet = 0; run_type = 8'h00;
    endfunction

    function automatic void emit_word();
        exp_ov = 1;
        for (int s = 0; s < int'(RAT); s++) begin
            exp_d[s*32 +: 32] = (s < mq_d.size()) ? mq_d[s] : 32'hE0E0E0E0;
            exp_c[s*4 +: 4]   = (s < mq_c.size()) ? mq_c[s] : 4'hF;
        end
        mq_d.delete();
        mq_c.delete();
    endfunction

    function automatic void model_column(input logic v, input logic [31:0] d, input logic [3:0] c);
        bit start, seq, mis;
        exp_ov = 0;
        exp_ae = 0;
        if (!v) return;
        start = (d[7:0] == 8'hDF) && c[0] && (d[15:8] == 8'h55) && !c[1];
        seq   = (d[7:0] == 8'h59) && (c == 4'b0001) && (d[23:8] == 16'h0) &&
                ((d[31:24] == 8'h80) || (d[31:24] == 8'hC0));
        mis = 0;
        for (int k = 1; k < int'(LANES); k++)
            if (d[8*k +: 8] == 8'hDF && c[k]) mis = 1;
        exp_ae = mis;
        if (start && mq_d.size() != 0) emit_word();
        mq_d.push_back(d);
        mq_c.push_back(c);
        if (mq_d.size() == int'(RAT)) emit_word();
        if (seq) begin
            quiet = 0;
            if (tracking && d[31:24] == run_type) begin
                run_len++;
            end else begin
                tracking = 1;
                run_type = d[31:24];
                run_len  = 1;
                faulted  = 0;
            end
            if (run_len >= int'(FCNT)) faulted = 1;
        end else if (tracking) begin
            quiet++;
            if (quiet >= int'(CCOLS)) begin
                tracking = 0; faulted = 0; run_len = 0; quiet = 0;
            end
        end
        exp_lf = faulted && run_type == 8'h80;
        exp_rf = faulted && run_type == 8'hC0;
    endfunction

    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] c);
        in_valid = v;
        rxd_in   = d;
        rxc_in   = c;
        model_column(v, d, c);
        @(posedge rxclk);
        #1;
        check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            check_eq("rxd64", rxd64, exp_d);
            check_eq("rxc8", 64'(rxc8), 64'(exp_c));
        end
        check_eq("local_fault", 64'(local_fault), 64'(exp_lf));
        check_eq("remote_fault", 64'(remote_fault), 64'(exp_rf));
        check_eq("align_err", 64'(align_err), 64'(exp_ae));
        in_valid = 0;
    endtask

    task automatic do_reset();
        in_valid = 0;
        reset = 1;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_rxd64", rxd64, 64'd0);
        check_eq("rst_rxc8", 64'(rxc8), 64'd0);
        check_eq("rst_faults", 64'({local_fault, remote_fault}), 64'd0);
        check_eq("rst_align_err", 64'(align_err), 64'd0);
        model_reset();
        @(posedge rxclk);
        #1;
        reset = 0;
    endtask

    localparam logic [31:0] C_IDLE  = 32'hE0E0E0E0;
    localparam logic [31:0] C_START = 32'h555555DF;
    localparam logic [31:0] C_LOC   = 32'h80000059;
    localparam logic [31:0] C_REM   = 32'hC0000059;

    task automatic rand_step();
        int r;
        logic [31:0] d;
        r = $urandom_range(0, 99);
        d = $urandom;
        if (r < 10)      step(1'b0, d, 4'h0);
        else if (r < 25) step(1'b1, C_IDLE, 4'hF);
        else if (r < 42) step(1'b1, d, 4'h0);
        else if (r < 52) step(1'b1, {d[31:16], 16'h55DF}, 4'h1);
        else if (r < 70) step(1'b1, C_LOC, 4'h1);
        else if (r < 88) step(1'b1, C_REM, 4'h1);
        else if (r < 94) step(1'b1, {d[31:24], 8'hDF, d[15:0]}, 4'b0100);
        else             step(1'b1, {8'hDF, d[23:0]}, 4'b1000);
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        // Aligned Start followed by a data column
        step(1'b1, C_START, 4'h1);
        step(1'b1, 32'hD0D0D0D0, 4'h0);
        check_eq("t1_word", rxd64, 64'hD0D0D0D0_555555DF);
        check_eq("t1_ctrl", 64'(rxc8), 64'h01);

        // Start arriving at phase 1 forces an IDLE-padded flush
        step(1'b1, C_IDLE, 4'hF);
        step(1'b1, C_START, 4'h1);
        check_eq("t2_flush_hi", 64'(rxd64[63:32]), 64'hE0E0E0E0);
        check_eq("t2_flush_c", 64'(rxc8[7:4]), 64'hF);
        step(1'b1, 32'h12345678, 4'h0);
        check_eq("t2_start_lane0", 64'(rxd64[7:0]), 64'hDF);

        // Local fault declaration and clearing
        for (int i = 0; i < 4; i++) step(1'b1, C_LOC, 4'h1);
        check_eq("t3_local_set", 64'(local_fault), 64'd1);
        for (int i = 0; i < 127; i++) step(1'b1, C_IDLE, 4'hF);
        check_eq("t3_local_held", 64'(local_fault), 64'd1);
        step(1'b1, C_IDLE, 4'hF);
        check_eq("t3_local_clr", 64'(local_fault), 64'd0);

        // Type change then a single opposite Sequence leaves FAULT
        for (int i = 0; i < 3; i++) step(1'b1, C_LOC, 4'h1);
        for (int i = 0; i < 4; i++) step(1'b1, C_REM, 4'h1);
        check_eq("t4_remote_set", 64'(remote_fault), 64'd1);
        step(1'b1, C_LOC, 4'h1);
        check_eq("t4_both_clr", 64'({local_fault, remote_fault}), 64'd0);

        // Misplaced Start in lane 2
        step(1'b1, 32'h00DF0000, 4'b0100);
        check_eq("t5_align_err", 64'(align_err), 64'd1);
        step(1'b0, 32'h0, 4'h0);
        check_eq("t5_align_pulse", 64'(align_err), 64'd0);

        // Reset with a partial word pending
        do_reset();
        step(1'b1, 32'hAAAAAAAA, 4'h0);
        do_reset();
        step(1'b1, 32'h11111111, 4'h0);
        step(1'b1, 32'h22222222, 4'h3);
        check_eq("t6_word", rxd64, 64'h22222222_11111111);
        check_eq("t6_ctrl", 64'(rxc8), 64'h30);

        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 600; i++) rand_step();
            for (int i = 0; i < 130; i++) step(1'b1, C_IDLE, 4'hF);
        end
        do_reset();
        for (int i = 0; i < 200; i++) rand_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
